// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the execute-stage HI/LO
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W = 32;

    // Multiply/divide operation encodings as presented on iOp
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer states: RUN iterates one bit per cycle, SIGN applies the
    // sign fix-up and commits HI/LO
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_if
// Description : ID/EX-side bundle for the HI/LO multiply/divide unit. The
//               master is the pipeline, the slave is hilo_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              iStart;
    logic [1:0]        iOp;
    logic [DATA_W-1:0] iRegOut1;
    logic [DATA_W-1:0] iRegOut2;
    logic              iHiLoWrite;
    logic              iHL;
    logic              iFlush;
    logic              oBusy;
    logic              oDone;
    logic [DATA_W-1:0] oHiLo;
    logic [DATA_W-1:0] oHi;
    logic [DATA_W-1:0] oLo;

    modport master (
        output iStart, iOp, iRegOut1, iRegOut2, iHiLoWrite, iHL, iFlush,
        input  oBusy, oDone, oHiLo, oHi, oLo
    );

    modport slave (
        input  iStart, iOp, iRegOut1, iRegOut2, iHiLoWrite, iHL, iFlush,
        output oBusy, oDone, oHiLo, oHi, oLo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter_core
// Description : Unsigned one-bit-per-cycle datapath. A single 2*DATA_W
//               accumulator serves as the shift-add product register for
//               multiplies and as {remainder, quotient} for restoring
//               division.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                load,
    input  wire logic                step,
    input  wire logic                op_is_div,
    input  wire logic [DATA_W-1:0]   opa,
    input  wire logic [DATA_W-1:0]   opb,
    output logic                     last,
    output logic [2*DATA_W-1:0]      product,
    output logic [DATA_W-1:0]        quotient,
    output logic [DATA_W-1:0]        remainder
);

    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_opb;
    logic                r_is_div;
    logic [CNT_W-1:0]    r_count;

    logic [DATA_W:0]     w_add_sum;
    logic [DATA_W:0]     w_trial;
    logic                w_trial_ge;
    logic [DATA_W-1:0]   w_sub;
    logic [2*DATA_W-1:0] w_acc_next;

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, keeping the carry for the right shift.
    assign w_add_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                     + (r_acc[0] ? {1'b0, r_opb} : '0);

    // Divide: trial remainder is the partial remainder shifted left with the
    // next dividend bit. The true difference always fits in DATA_W bits when
    // non-negative, so a modular subtract of the low bits is exact.
    assign w_trial    = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_trial_ge = (w_trial >= {1'b0, r_opb});
    assign w_sub      = w_trial[DATA_W-1:0] - r_opb;

    // Next accumulator value for one iteration
    always_comb begin
        w_acc_next = r_acc;
        if (r_is_div) begin
            if (w_trial_ge) begin
                w_acc_next = {w_sub, r_acc[DATA_W-2:0], 1'b1};
            end else begin
                w_acc_next = {r_acc[2*DATA_W-2:0], 1'b0};
            end
        end else begin
            w_acc_next = {w_add_sum, r_acc[DATA_W-1:1]};
        end
    end

    // Operand load, iteration and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_count  <= '0;
        end else if (load) begin
            r_acc    <= {{DATA_W{1'b0}}, opa};
            r_opb    <= opb;
            r_is_div <= op_is_div;
            r_count  <= '0;
        end else if (step) begin
            r_acc    <= w_acc_next;
            r_count  <= r_count + 1'b1;
        end
    end

    assign last      = (r_count == CNT_W'(DATA_W - 1));
    assign product   = r_acc;
    assign quotient  = r_acc[DATA_W-1:0];
    assign remainder = r_acc[2*DATA_W-1:DATA_W];

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv
// Description : Execute-stage multiply/divide unit owning the architectural
//               HI/LO registers. Sequences the iterative core, applies the
//               signed fix-up, and provides the MTHI/MTLO write port and the
//               MFHI/MFLO read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hilo_muldiv_if.slave     bus
);

    md_state_t           r_state;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_busy;
    logic                r_done;

    logic                w_signed;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic                w_load;
    logic                w_step;
    logic                w_last;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0]   w_quotient;
    logic [DATA_W-1:0]   w_remainder;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_q_fix;
    logic [DATA_W-1:0]   w_r_fix;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    // Signed ops work on magnitudes; 0x80000000 maps to 2^31 as unsigned
    assign w_signed = ~bus.iOp[0];
    assign w_neg_a  = w_signed & bus.iRegOut1[DATA_W-1];
    assign w_neg_b  = w_signed & bus.iRegOut2[DATA_W-1];
    assign w_abs_a  = w_neg_a ? -bus.iRegOut1 : bus.iRegOut1;
    assign w_abs_b  = w_neg_b ? -bus.iRegOut2 : bus.iRegOut2;

    // A start is only honoured from IDLE; a flush in RUN freezes the core
    assign w_load = (r_state == IDLE) & bus.iStart & ~bus.iFlush;
    assign w_step = (r_state == RUN) & ~bus.iFlush;

    muldiv_iter_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .step      (w_step),
        .op_is_div (bus.iOp[1]),
        .opa       (w_abs_a),
        .opb       (w_abs_b),
        .last      (w_last),
        .product   (w_product),
        .quotient  (w_quotient),
        .remainder (w_remainder)
    );

    // Sign fix-up: remainder follows the dividend sign, quotient/product
    // follow the XOR of operand signs
    assign w_prod_fix = r_neg_q ? -w_product   : w_product;
    assign w_q_fix    = r_neg_q ? -w_quotient  : w_quotient;
    assign w_r_fix    = r_neg_r ? -w_remainder : w_remainder;
    assign w_res_hi   = r_is_div ? w_r_fix : w_prod_fix[2*DATA_W-1:DATA_W];
    assign w_res_lo   = r_is_div ? w_q_fix : w_prod_fix[DATA_W-1:0];

    // Sequencer, HI/LO registers and registered status; the SIGN commit is
    // written after the MT write so it wins on a shared edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.iHiLoWrite) begin
                if (bus.iHL) begin
                    r_hi <= bus.iRegOut1;
                end else begin
                    r_lo <= bus.iRegOut1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_is_div <= bus.iOp[1];
                        r_neg_q  <= w_neg_a ^ w_neg_b;
                        r_neg_r  <= w_neg_a;
                    end
                end
                RUN: begin
                    if (bus.iFlush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_last) begin
                        r_state <= SIGN;
                    end
                end
                SIGN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.iFlush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oBusy = r_busy;
    assign bus.oDone = r_done;
    assign bus.oHi   = r_hi;
    assign bus.oLo   = r_lo;
    assign bus.oHiLo = bus.iHL ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_muldiv
// Description : Self-checking bench for hilo_muldiv: table of mul/div
//               vectors plus flush, MT-write, same-edge and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hilo_muldiv_if #(.DATA_W(32)) bus ();

    hilo_muldiv #(.DATA_W(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] hi, input logic [31:0] lo, input bit push);
        exp_t e;
        bus.iOp      = op;
        bus.iRegOut1 = rs;
        bus.iRegOut2 = rt;
        bus.iStart   = 1'b1;
        tick();
        bus.iStart     = 1'b0;
        bus.iHiLoWrite = 1'b0;
        if (push) begin
            e.hi = hi;
            e.lo = lo;
            sb.push_back(e);
        end
    endtask

    task automatic mt_write(input logic sel_hi, input logic [31:0] data);
        bus.iHiLoWrite = 1'b1;
        bus.iHL        = sel_hi;
        bus.iRegOut1   = data;
        tick();
        bus.iHiLoWrite = 1'b0;
    endtask

    // Waits for oDone, counting busy samples from now, then scores HI/LO
    task automatic wait_result(input string nm, input int exp_busy);
        int   busy_cnt = 0;
        int   cyc      = 0;
        exp_t e;
        while (!bus.oDone && cyc < 100) begin
            if (bus.oBusy) busy_cnt++;
            tick();
            cyc++;
        end
        if (cyc >= 100) begin
            $display("FAIL %s done_timeout: oDone never seen", nm);
            check({nm, "_done"}, {31'b0, bus.oDone}, 32'd1);
            return;
        end
        check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({nm, "_busy_low"}, {31'b0, bus.oBusy}, 32'd0);
        if (sb.size() == 0) begin
            check({nm, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({nm, "_hi"}, bus.oHi, e.hi);
        check({nm, "_lo"}, bus.oLo, e.lo);
        bus.iHL = 1'b1;
        #1;
        check({nm, "_mfhi"}, bus.oHiLo, e.hi);
        bus.iHL = 1'b0;
        #1;
        check({nm, "_mflo"}, bus.oHiLo, e.lo);
        tick();
        check({nm, "_done_pulse"}, {31'b0, bus.oDone}, 32'd0);
    endtask

    // Watches a window of cycles and reports whether oDone ever rose
    task automatic watch_done(input int cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.oDone) seen = 1'b1;
            tick();
        end
    endtask

    initial begin
        bit seen;

        vecs[0] = '{"mult_neg3x7",   2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{"multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{"div_neg7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"divu_by0",      2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4] = '{"div_ovf",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{"div_neg_by0",   2'b10, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'h0000_0001};
        vecs[6] = '{"divu_big",      2'b11, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF};
        vecs[7] = '{"mult_min_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{"mult_max_min",  2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};

        bus.iStart     = 1'b0;
        bus.iOp        = 2'b00;
        bus.iRegOut1   = '0;
        bus.iRegOut2   = '0;
        bus.iHiLoWrite = 1'b0;
        bus.iHL        = 1'b0;
        bus.iFlush     = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", {31'b0, bus.oBusy}, 32'd0);
        check("reset_done", {31'b0, bus.oDone}, 32'd0);
        check("reset_hi",   bus.oHi, 32'd0);
        check("reset_lo",   bus.oLo, 32'd0);
        check("reset_hilo", bus.oHiLo, 32'd0);

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, 1'b1);
            wait_result(vecs[i].name, 33);
        end

        // Flush at cycle 10 of a DIV with HI/LO preloaded
        mt_write(1'b1, 32'h11);
        mt_write(1'b0, 32'h22);
        launch(2'b10, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        bus.iFlush = 1'b1;
        tick();
        bus.iFlush = 1'b0;
        check("flush_busy_drop", {31'b0, bus.oBusy}, 32'd0);
        watch_done(40, seen);
        check("flush_no_done", {31'b0, seen}, 32'd0);
        check("flush_hi", bus.oHi, 32'h11);
        check("flush_lo", bus.oLo, 32'h22);

        // MTHI mid-MULT, plus an ignored second start during busy
        launch(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        bus.iHiLoWrite = 1'b1;
        bus.iHL        = 1'b1;
        bus.iRegOut1   = 32'h55;
        bus.iStart     = 1'b1;
        bus.iOp        = 2'b01;
        bus.iRegOut2   = 32'd9;
        tick();
        bus.iHiLoWrite = 1'b0;
        bus.iStart     = 1'b0;
        check("mthi_busy_hi", bus.oHi, 32'h55);
        check("mthi_busy_still", {31'b0, bus.oBusy}, 32'd1);
        wait_result("mult_2x3", 29);
        watch_done(40, seen);
        check("ignored_start_no_done", {31'b0, seen}, 32'd0);

        // Same-edge MTLO and MULTU start: write lands, operands latched
        bus.iHiLoWrite = 1'b1;
        bus.iHL        = 1'b0;
        launch(2'b01, 32'h77, 32'd2, 32'd0, 32'hEE, 1'b1);
        check("same_edge_lo", bus.oLo, 32'h77);
        wait_result("same_edge_mul", 33);

        // Reset mid-RUN discards the operation and clears HI/LO
        mt_write(1'b1, 32'hAA);
        launch(2'b01, 32'h1234, 32'h5678, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, bus.oBusy}, 32'd0);
        check("rst_mid_hi", bus.oHi, 32'd0);
        check("rst_mid_lo", bus.oLo, 32'd0);
        bus.iHL = 1'b1;
        #1;
        check("rst_mid_hilo", bus.oHiLo, 32'd0);
        launch(2'b01, 32'd4, 32'd5, 32'd0, 32'd20, 1'b1);
        wait_result("multu_4x5", 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
